pixel_alu: RTL and testbench

//  Frame-buffer processing engine on the mem_controller ALU port. On start it streams

---
 rtl/pixel_pkg.sv | 35 +++
 rtl/pixel_alu_if.sv | 37 +++
 rtl/pixel_op.sv | 34 +++
 rtl/pixel_alu.sv | 128 ++++++++++++
 tb/tb_pixel_alu.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel-processing definitions: pixel/channel widths, ALU op codes,
// engine FSM states and a luma helper used by the op block.
package pixel_pkg;

    localparam int unsigned PIX_W  = 12;
    localparam int unsigned CH_W   = 4;
    localparam int unsigned MODE_W = 3;

    // Codes 6 and 7 are unassigned and behave as pass-through.
    typedef enum logic [MODE_W-1:0] {
        MODE_PASS   = 3'd0,
        MODE_INVERT = 3'd1,
        MODE_GRAY   = 3'd2,
        MODE_THRESH = 3'd3,
        MODE_RED    = 3'd4,
        MODE_SWAP   = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // y = (R + 2G + B) >> 2; the 6-bit sum never exceeds 60, so y fits in a channel.
    function automatic logic [CH_W-1:0] luma(input logic [PIX_W-1:0] pix);
        logic [CH_W+1:0] sum;
        sum = {2'b00, pix[3*CH_W-1:2*CH_W]}
            + {1'b0, pix[2*CH_W-1:CH_W], 1'b0}
            + {2'b00, pix[CH_W-1:0]};
        return sum[CH_W+1:2];
    endfunction

endpackage

// File: rtl/pixel_alu_if.sv
// Memory-controller ALU port: one read channel with fixed latency and one
// write channel, plus the arbiter grant.
interface pixel_alu_if
    import pixel_pkg::*;
#(
    parameter int unsigned RADDR_W = 13,
    parameter int unsigned WADDR_W = 19
);

    logic               gnt;
    logic [RADDR_W-1:0] raddr_alu;
    logic [PIX_W-1:0]   rdata_alu;
    logic [WADDR_W-1:0] waddr_alu;
    logic [PIX_W-1:0]   wdata_alu;
    logic               wen_alu;

    // Engine side.
    modport master (
        input  gnt,
        input  rdata_alu,
        output raddr_alu,
        output waddr_alu,
        output wdata_alu,
        output wen_alu
    );

    // Memory-controller side.
    modport slave (
        output gnt,
        output rdata_alu,
        input  raddr_alu,
        input  waddr_alu,
        input  wdata_alu,
        input  wen_alu
    );

endinterface

// File: rtl/pixel_op.sv
// Combinational per-pixel operation on an RGB444 pixel {R,G,B}.
module pixel_op
    import pixel_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic [CH_W-1:0]   thresh,
    input  logic [PIX_W-1:0]  pix,
    output logic [PIX_W-1:0]  res
);

    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] y;

    assign r = pix[3*CH_W-1:2*CH_W];
    assign g = pix[2*CH_W-1:CH_W];
    assign b = pix[CH_W-1:0];
    assign y = luma(pix);

    // Select the result for the latched mode; unassigned codes pass through.
    always_comb begin
        res = pix;
        case (mode_e'(mode))
            MODE_INVERT: res = ~pix;
            MODE_GRAY:   res = {y, y, y};
            MODE_THRESH: res = (y >= thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            MODE_RED:    res = {r, {CH_W{1'b0}}, {CH_W{1'b0}}};
            MODE_SWAP:   res = {b, g, r};
            default:     res = pix;
        endcase
    end

endmodule

// File: rtl/pixel_alu.sv
// Frame-buffer streaming engine: reads NPIX pixels, applies pixel_op and writes
// the results at WBASE onward, at up to one pixel per granted clock.
module pixel_alu
    import pixel_pkg::*;
#(
    parameter int unsigned NPIX     = 8192,
    parameter int unsigned RADDR_W  = 13,
    parameter int unsigned WADDR_W  = 19,
    parameter int unsigned WBASE    = 0,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [CH_W-1:0]   thresh,
    pixel_alu_if.master       mem,
    output logic              busy,
    output logic              done
);

    localparam int unsigned        CNT_W   = $clog2(NPIX + 1);
    localparam logic [RADDR_W-1:0] LAST_RD = RADDR_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]   NPIX_C  = CNT_W'(NPIX);
    localparam logic [WADDR_W-1:0] WBASE_C = WADDR_W'(WBASE);

    state_e              state_q;
    state_e              state_d;
    logic [RADDR_W-1:0]  rd_idx_q;
    logic [CNT_W-1:0]    wr_cnt_q;
    logic [MODE_W-1:0]   mode_q;
    logic [CH_W-1:0]     thresh_q;
    logic [READ_LAT-1:0] vld_q;
    logic                wen_q;
    logic [WADDR_W-1:0]  waddr_q;
    logic [PIX_W-1:0]    wdata_q;
    logic [PIX_W-1:0]    op_res;
    logic                accept;
    logic                rd_fire;
    logic                vld_last;

    assign accept   = (state_q == StIdle) && start;
    assign rd_fire  = (state_q == StRun) && mem.gnt;
    assign vld_last = vld_q[READ_LAT-1];

    pixel_op u_pixel_op (
        .mode   (mode_q),
        .thresh (thresh_q),
        .pix    (mem.rdata_alu),
        .res    (op_res)
    );

    // Next state: RUN ends on the last issued read, DRAIN on the last write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (mem.gnt && (rd_idx_q == LAST_RD)) state_d = StDrain;
            StDrain: if (wr_cnt_q == NPIX_C) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Read side: latch op config on start, advance the read index on each grant.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rd_idx_q <= '0;
            mode_q   <= '0;
            thresh_q <= '0;
        end else if (accept) begin
            rd_idx_q <= '0;
            mode_q   <= mode;
            thresh_q <= thresh;
        end else if (rd_fire && (rd_idx_q != LAST_RD)) begin
            rd_idx_q <= rd_idx_q + 1'b1;
        end
    end

    // Valid tokens track issued reads through the fixed memory latency.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_fire;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Compute stage: register the op result and its address; writes stay in order,
    // so a running write count is the pixel index.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            wen_q <= vld_last;
            if (accept) begin
                wr_cnt_q <= '0;
            end else if (vld_last) begin
                wdata_q  <= op_res;
                waddr_q  <= WBASE_C + WADDR_W'(wr_cnt_q);
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign mem.raddr_alu = rd_idx_q;
    assign mem.waddr_alu = waddr_q;
    assign mem.wdata_alu = wdata_q;
    assign mem.wen_alu   = wen_q;
    assign busy          = (state_q == StRun) || (state_q == StDrain);
    assign done          = (state_q == StDone);

endmodule

// File: tb/tb_pixel_alu.sv
// Scoreboard bench for pixel_alu: two instances (16 pixels at base 0, 8 pixels
// near the top of the write space) each with a 1-clock-latency memory model.
module tb_pixel_alu;
    import pixel_pkg::*;

    localparam int unsigned NPIX_A  = 16;
    localparam int unsigned NPIX_B  = 8;
    localparam int unsigned WBASE_A = 0;
    localparam int unsigned WBASE_B = (1 << 19) - 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, start_a, start_b;
    logic [2:0] mode_a, mode_b;
    logic [3:0] thresh_a, thresh_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic       toggle_gnt_b = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    logic [11:0] mem_arr_a [NPIX_A];
    logic [11:0] mem_arr_b [NPIX_B];
    logic [18:0] qa_addr[$];
    logic [18:0] qb_addr[$];
    logic [11:0] qa_data[$];
    logic [11:0] qb_data[$];

    pixel_alu_if #(.RADDR_W(13), .WADDR_W(19)) mem_a ();
    pixel_alu_if #(.RADDR_W(13), .WADDR_W(19)) mem_b ();

    pixel_alu #(.NPIX(NPIX_A), .RADDR_W(13), .WADDR_W(19), .WBASE(WBASE_A), .READ_LAT(1)) u_dut_a (
        .sys_clk (clk),
        .rst     (rst_a),
        .start   (start_a),
        .mode    (mode_a),
        .thresh  (thresh_a),
        .mem     (mem_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    pixel_alu #(.NPIX(NPIX_B), .RADDR_W(13), .WADDR_W(19), .WBASE(WBASE_B), .READ_LAT(1)) u_dut_b (
        .sys_clk (clk),
        .rst     (rst_b),
        .start   (start_b),
        .mode    (mode_b),
        .thresh  (thresh_b),
        .mem     (mem_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models, one clock of read latency.
    always @(posedge clk) mem_a.rdata_alu <= mem_arr_a[mem_a.raddr_alu[3:0]];
    always @(posedge clk) mem_b.rdata_alu <= mem_arr_b[mem_b.raddr_alu[2:0]];

    always @(negedge clk) mem_b.gnt <= toggle_gnt_b ? ~mem_b.gnt : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] golden(input logic [2:0] m, input logic [3:0] t,
                                           input logic [11:0] p);
        logic [3:0] r, g, b, y;
        int s;
        r = p[11:8];
        g = p[7:4];
        b = p[3:0];
        s = int'(r) + 2 * int'(g) + int'(b);
        y = 4'(s / 4);
        case (m)
            3'd1:    return ~p;
            3'd2:    return {y, y, y};
            3'd3:    return (y >= t) ? 12'hFFF : 12'h000;
            3'd4:    return {r, 8'h00};
            3'd5:    return {b, g, r};
            default: return p;
        endcase
    endfunction

    // Scoreboard monitors: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_a.wen_alu === 1'b1) begin
            check("a_busy_on_write", 32'(busy_a), 1);
            if (qa_addr.size() == 0) begin
                check("a_write_expected", 32'(qa_addr.size()), 1);
            end else begin
                check("a_waddr", 32'(mem_a.waddr_alu), 32'(qa_addr.pop_front()));
                check("a_wdata", 32'(mem_a.wdata_alu), 32'(qa_data.pop_front()));
            end
        end
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end

    always @(negedge clk) begin
        if (mem_b.wen_alu === 1'b1) begin
            check("b_busy_on_write", 32'(busy_b), 1);
            if (qb_addr.size() == 0) begin
                check("b_write_expected", 32'(qb_addr.size()), 1);
            end else begin
                check("b_waddr", 32'(mem_b.waddr_alu), 32'(qb_addr.pop_front()));
                check("b_wdata", 32'(mem_b.wdata_alu), 32'(qb_data.pop_front()));
            end
        end
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic go_a(input logic [2:0] m, input logic [3:0] t, output int s);
        @(negedge clk);
        for (int i = 0; i < int'(NPIX_A); i++) begin
            qa_addr.push_back(19'(WBASE_A + i));
            qa_data.push_back(golden(m, t, mem_arr_a[i]));
        end
        mode_a   = m;
        thresh_a = t;
        start_a  = 1'b1;
        s        = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic go_b(input logic [2:0] m, input logic [3:0] t, output int s);
        @(negedge clk);
        for (int i = 0; i < int'(NPIX_B); i++) begin
            qb_addr.push_back(19'(WBASE_B + i));
            qb_data.push_back(golden(m, t, mem_arr_b[i]));
        end
        mode_b   = m;
        thresh_b = t;
        start_b  = 1'b1;
        s        = cyc;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    // Bounded wait for done; optionally checks start-to-done latency (0 = skip).
    task automatic wait_done(input bit sel_b, input string tag, input int s, input int exp_lat,
                             input int d0);
        int n = 0;
        bit seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            seen = sel_b ? done_b : done_a;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen && exp_lat > 0) check({tag, "_done_latency"}, 32'(cyc - s), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_done_one_clk"}, 32'(sel_b ? done_b : done_a), 0);
        check({tag, "_busy_after"}, 32'(sel_b ? busy_b : busy_a), 0);
        repeat (3) @(negedge clk);
        check({tag, "_queue_drained"}, 32'(sel_b ? qb_addr.size() : qa_addr.size()), 0);
        check({tag, "_done_once"}, 32'((sel_b ? done_cnt_b : done_cnt_a) - d0), 1);
    endtask

    initial begin
        int s;
        int n;
        int d0;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        mode_a = '0; mode_b = '0; thresh_a = '0; thresh_b = '0;
        mem_a.gnt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wen", 32'(mem_a.wen_alu), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_raddr", 32'(mem_a.raddr_alu), 0);
        check("rst_waddr", 32'(mem_a.waddr_alu), 0);
        check("rst_wdata", 32'(mem_a.wdata_alu), 0);
        check("rst_b_wen", 32'(mem_b.wen_alu), 0);
        check("rst_b_busy", 32'(busy_b), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Pass-through, identity data, ideal grant: latency start -> done = NPIX+3.
        for (int i = 0; i < int'(NPIX_A); i++) mem_arr_a[i] = 12'(i);
        d0 = done_cnt_a;
        go_a(3'd0, 4'd0, s);
        wait_done(1'b0, "pass", s, NPIX_A + 3, d0);

        // Gray and threshold, with 12'hF84 (y = 8) at index 0.
        for (int i = 0; i < int'(NPIX_A); i++) mem_arr_a[i] = 12'($urandom);
        mem_arr_a[0] = 12'hF84;
        d0 = done_cnt_a;
        go_a(3'd2, 4'd0, s);
        wait_done(1'b0, "gray", s, NPIX_A + 3, d0);
        d0 = done_cnt_a;
        go_a(3'd3, 4'd9, s);
        wait_done(1'b0, "thresh", s, NPIX_A + 3, d0);

        // Restart attempt with new mode mid-pass is ignored.
        d0 = done_cnt_a;
        go_a(3'd5, 4'd0, s);
        repeat (4) @(negedge clk);
        mode_a = 3'd1; thresh_a = 4'd3; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, "restart_ignored", s, NPIX_A + 3, d0);

        // Reset while pixel 5 is being written.
        go_a(3'd1, 4'd0, s);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (n < 100 && !(mem_a.wen_alu === 1'b1 && mem_a.waddr_alu == 19'd5));
        check("rst_mid_reached_px5", 32'(mem_a.waddr_alu), 5);
        d0 = done_cnt_a;
        rst_a = 1'b1;
        #1;
        check("rst_mid_wen", 32'(mem_a.wen_alu), 0);
        check("rst_mid_busy", 32'(busy_a), 0);
        qa_addr.delete();
        qa_data.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt_a - d0), 0);
        d0 = done_cnt_a;
        go_a(3'd4, 4'd0, s);
        wait_done(1'b0, "after_rst", s, NPIX_A + 3, d0);

        // Grant toggling every clock: still 8 ordered writes and one done.
        for (int i = 0; i < int'(NPIX_B); i++) mem_arr_b[i] = 12'($urandom);
        toggle_gnt_b = 1'b1;
        d0 = done_cnt_b;
        go_b(3'd5, 4'd0, s);
        wait_done(1'b1, "gnt_toggle", s, 0, d0);
        toggle_gnt_b = 1'b0;
        repeat (2) @(negedge clk);

        // Write address wraps past 2^19-1; invert of black gives white.
        for (int i = 0; i < int'(NPIX_B); i++) mem_arr_b[i] = 12'h000;
        d0 = done_cnt_b;
        go_b(3'd1, 4'd0, s);
        wait_done(1'b1, "wrap", s, NPIX_B + 3, d0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
